score_ascii_keeper: RTL and testbench
=====================================

Name: score_ascii_keeper

Overview:
- Upstream feeder of the score text overlay.
- Keeps both players' scores as 2-digit BCD counters and detects the winner.
- Presents the scores as ASCII codes to the char-code lookup stage, plus the winning player number.
- Driven by point pulses from the game logic, in the 65 MHz pixel clock domain.

Parameters:
- WIN_SCORE, 10, score (1..99) at which a player wins; values outside 1..99 are illegal.
- DIG_W, 14, width of each ASCII digit output bus; bits [6:0] carry the code, upper bits are 0.

Ports:
- clk  in  1  system/pixel clock.
- rst  in  1  synchronous, active-low reset.
- my_point  in  1  level from game logic; each rising edge awards player 1 one point.
- op_point  in  1  level from game logic; each rising edge awards player 2 one point.
- new_game  in  1  rising edge clears scores and restarts play.
- my_score_ASCII_1  out  DIG_W  player 1 tens digit, ASCII.
- my_score_ASCII_0  out  DIG_W  player 1 units digit, ASCII.
- op_score_ASCII_1  out  DIG_W  player 2 tens digit, ASCII.
- op_score_ASCII_0  out  DIG_W  player 2 units digit, ASCII.
- number_of_player  out  7  ASCII winner digit: '1' = 7'h31, '2' = 7'h32; space 7'h20 while no winner.
- game_over  out  1  high while in WON.

Behaviour:
- Reset: active when rst == 0, sampled on the clk rising edge.
  - All digit outputs = {7'b0, 7'h30}, i.e. "00".
  - number_of_player = 7'h20; game_over = 0.
  - FSM = PLAY; edge-detect history registers = 0.
- Edge detection:
  - One register per input (my_point, op_point, new_game).
  - A pulse fires when the input is 1 and its history register is 0.
  - A held level counts exactly once.
- BCD counter, per player: units increments 0..9; at 9 it wraps to 0 and tens increments. Tens saturates at 9; the counter holds at 99.
- FSM:
  - PLAY:
    - A point pulse increments that player's counter.
    - If the post-increment value equals WIN_SCORE, go to WON. number_of_player becomes 7'h31 (player 1) or 7'h32 (player 2); game_over becomes 1 in the same cycle the score updates.
  - WON:
    - Point pulses are ignored and scores freeze.
    - A new_game pulse clears both counters to 00, sets number_of_player = 7'h20, game_over = 0, and returns to PLAY.
  - new_game pulse in PLAY: clears both counters; state stays PLAY.
- Latency: all outputs are registered. An input rising edge at cycle N is sampled by the edge register at N; the updated output is visible after the cycle N+1 edge, i.e. 2 clk.
- Simultaneous events:
  - Both point pulses in the same cycle: both counters increment.
  - Both players reach WIN_SCORE in the same cycle: player 1 wins (tie-break fixed).
  - new_game together with any point pulse: new_game has priority; scores = 00 and the point is discarded.
- ASCII conversion: code = 7'h30 + BCD digit. The conversion is registered together with the counters, with no extra stage.
- Reset mid-game: immediate return to the reset values at the next clk edge, regardless of state.

Optional Feature:
- LEAD_ZERO_BLANK_EN
- Defined: a tens digit of 0 is output as 7'h20 (space), so score 7 displays " 7". Units is never blanked.
- Undefined: the tens digit is always numeric ("07").
- Reset value of the tens outputs follows the same rule: 7'h20 when defined, 7'h30 when undefined.

Decomposition:
- Shared package score_pkg holds:
  - ASCII_ZERO = 7'h30, ASCII_SPACE = 7'h20, ASCII_ONE = 7'h31, ASCII_TWO = 7'h32.
  - FSM state encoding: PLAY = 1'b0, WON = 1'b1.
  - BCD digit width constant = 4.
- One sub-module, score_bcd_counter, instantiated once per player:
  - Inputs: clk, rst, clr, inc.
  - Outputs: tens[3:0], units[3:0].
  - Behaviour: saturating 00..99 with clr priority over inc.
- The top level holds the edge detectors, the FSM, the win compare and the ASCII mapping.

Test Plan:
- Reset: hold rst = 0 for 3 clk -> all four digit outputs = 7'h30, number_of_player = 7'h20, game_over = 0.
- Count: 3 my_point rising edges, each level held 5 clk -> my_score_ASCII_0 = 7'h33, tens stays 7'h30, op digits unchanged. Each update lands exactly 2 clk after its input edge.
- Carry and win: WIN_SCORE = 12, 12 op_point pulses:
  - After pulse 10: op digits = 7'h31 / 7'h30.
  - After pulse 12: game_over = 1 and number_of_player = 7'h32.
  - A further op_point leaves the score at 12.
- Tie-break: both players at 9, WIN_SCORE = 10, my_point and op_point rise in the same cycle -> both show "10", number_of_player = 7'h31.
- Restart priority: in WON, new_game and my_point rise together -> all digits 7'h30, game_over = 0, state PLAY, no point counted.
- Saturation and blanking: WIN_SCORE = 99, with LEAD_ZERO_BLANK_EN defined:
  - At score 5: tens = 7'h20.
  - After 99 points: digits 7'h39 / 7'h39 and game_over = 1.

Source files
------------

// File: rtl/score_ascii_keeper_pkg.sv
// score_pkg: ASCII codes, FSM encoding and BCD helpers
// shared by the score keeper and its BCD counter.
package score_pkg;

  localparam logic [6:0] ASCII_ZERO  = 7'h30;
  localparam logic [6:0] ASCII_SPACE = 7'h20;
  localparam logic [6:0] ASCII_ONE   = 7'h31;
  localparam logic [6:0] ASCII_TWO   = 7'h32;

  localparam int BCD_W = 4;

  typedef enum logic {
    PLAY = 1'b0,
    WON  = 1'b1
  } state_e;

  // saturating BCD increment of {tens, units}
  function automatic logic [2*BCD_W-1:0] bcd_next(
    input logic [BCD_W-1:0] t,
    input logic [BCD_W-1:0] u
  );
    if (t == 4'd9 && u == 4'd9) return {t, u};
    if (u == 4'd9) return {t + 4'd1, 4'd0};
    return {t, u + 4'd1};
  endfunction

  // binary value of a 2-digit BCD number
  function automatic logic [6:0] bcd_val(
    input logic [2*BCD_W-1:0] b
  );
    return {3'b0, b[7:4]} * 7'd10 + {3'b0, b[3:0]};
  endfunction

endpackage

// File: rtl/score_ascii_keeper_if.sv
// score_ascii_keeper_if: point/new-game pulses in,
// ASCII score digits and winner out.
interface score_ascii_keeper_if #(
  parameter int DIG_W = 14
) ();

  logic             my_point;
  logic             op_point;
  logic             new_game;
  logic [DIG_W-1:0] my_score_ASCII_1;
  logic [DIG_W-1:0] my_score_ASCII_0;
  logic [DIG_W-1:0] op_score_ASCII_1;
  logic [DIG_W-1:0] op_score_ASCII_0;
  logic [6:0]       number_of_player;
  logic             game_over;

  modport master (
    output my_point,
    output op_point,
    output new_game,
    input  my_score_ASCII_1,
    input  my_score_ASCII_0,
    input  op_score_ASCII_1,
    input  op_score_ASCII_0,
    input  number_of_player,
    input  game_over
  );

  modport slave (
    input  my_point,
    input  op_point,
    input  new_game,
    output my_score_ASCII_1,
    output my_score_ASCII_0,
    output op_score_ASCII_1,
    output op_score_ASCII_0,
    output number_of_player,
    output game_over
  );

endinterface

// File: rtl/score_bcd_counter.sv
// score_bcd_counter: 2-digit BCD score, saturating
// at 99, clear has priority over increment.
module score_bcd_counter
  import score_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] units
);

  logic [2*BCD_W-1:0] cnt_q, cnt_d;

  // next count: clear, else saturating increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = bcd_next(cnt_q[7:4], cnt_q[3:0]);
    end
  end

  // count register with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tens  = cnt_q[7:4];
  assign units = cnt_q[3:0];

endmodule

// File: rtl/score_ascii_keeper.sv
// score_ascii_keeper: BCD scores, winner FSM, ASCII out.
// Define LEAD_ZERO_BLANK_EN to blank a zero tens digit.
module score_ascii_keeper
  import score_pkg::*;
#(
  parameter int WIN_SCORE = 10,
  parameter int DIG_W     = 14
) (
  input logic                 clk,
  input logic                 rst,
  score_ascii_keeper_if.slave io
);

  // bit 2: new_game, bit 1: op_point, bit 0: my_point
  logic [2:0] smp_q;
  logic [2:0] hist_q;
  logic [2:0] rise;

  state_e     state_q, state_d;
  logic [6:0] npl_q, npl_d;

  logic       my_inc, op_inc, clr;
  logic [3:0] my_t, my_u, op_t, op_u;
  logic [7:0] my_nxt, op_nxt;
  logic [6:0] my_a1, my_a0, op_a1, op_a0;

  // input sample and one-cycle edge history
  always_ff @(posedge clk) begin
    if (!rst) begin
      smp_q  <= '0;
      hist_q <= '0;
    end else begin
      smp_q  <= {io.new_game, io.op_point, io.my_point};
      hist_q <= smp_q;
    end
  end

  assign rise = smp_q & ~hist_q;

  assign my_nxt = bcd_next(my_t, my_u);
  assign op_nxt = bcd_next(op_t, op_u);

  // FSM next state, counter controls and winner code
  always_comb begin
    state_d = state_q;
    npl_d   = npl_q;
    my_inc  = 1'b0;
    op_inc  = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      PLAY: begin
        if (rise[2]) begin
          clr   = 1'b1;
          npl_d = ASCII_SPACE;
        end else begin
          my_inc = rise[0];
          op_inc = rise[1];
          if (my_inc &&
              bcd_val(my_nxt) == 7'(WIN_SCORE)) begin
            state_d = WON;
            npl_d   = ASCII_ONE;
          end else if (op_inc &&
              bcd_val(op_nxt) == 7'(WIN_SCORE)) begin
            state_d = WON;
            npl_d   = ASCII_TWO;
          end
        end
      end
      WON: begin
        if (rise[2]) begin
          clr     = 1'b1;
          state_d = PLAY;
          npl_d   = ASCII_SPACE;
        end
      end
    endcase
  end

  // FSM state and winner register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= PLAY;
      npl_q   <= ASCII_SPACE;
    end else begin
      state_q <= state_d;
      npl_q   <= npl_d;
    end
  end

  score_bcd_counter u_my (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (my_inc),
    .tens  (my_t),
    .units (my_u)
  );

  score_bcd_counter u_op (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (op_inc),
    .tens  (op_t),
    .units (op_u)
  );

`ifdef LEAD_ZERO_BLANK_EN
  assign my_a1 = (my_t == 4'd0) ? ASCII_SPACE
                                : ASCII_ZERO + {3'b0, my_t};
  assign op_a1 = (op_t == 4'd0) ? ASCII_SPACE
                                : ASCII_ZERO + {3'b0, op_t};
`else
  assign my_a1 = ASCII_ZERO + {3'b0, my_t};
  assign op_a1 = ASCII_ZERO + {3'b0, op_t};
`endif
  assign my_a0 = ASCII_ZERO + {3'b0, my_u};
  assign op_a0 = ASCII_ZERO + {3'b0, op_u};

  assign io.my_score_ASCII_1 = DIG_W'(my_a1);
  assign io.my_score_ASCII_0 = DIG_W'(my_a0);
  assign io.op_score_ASCII_1 = DIG_W'(op_a1);
  assign io.op_score_ASCII_0 = DIG_W'(op_a0);
  assign io.number_of_player = npl_q;
  assign io.game_over        = (state_q == WON);

endmodule

// File: tb/tb_score_ascii_keeper.sv
// tb_score_ascii_keeper: two keepers (win at 12 and 99)
// driven alike and checked against a score model.
module tb_score_ascii_keeper;

  logic clk = 1'b0;
  logic rst_r = 1'b0;
  logic my_r = 1'b0;
  logic op_r = 1'b0;
  logic ng_r = 1'b0;

  int checks = 0;
  int fails  = 0;

  int wsc[2] = '{12, 99};
  int ms[2], os[2], wn[2];
  bit s1m, s1o, s1n, s2m, s2o, s2n;

  always #5 clk = ~clk;

  score_ascii_keeper_if #(.DIG_W(14)) ifa ();
  score_ascii_keeper_if #(.DIG_W(14)) ifb ();

  assign ifa.my_point = my_r;
  assign ifa.op_point = op_r;
  assign ifa.new_game = ng_r;
  assign ifb.my_point = my_r;
  assign ifb.op_point = op_r;
  assign ifb.new_game = ng_r;

  score_ascii_keeper #(.WIN_SCORE(12), .DIG_W(14)) dut_a (
    .clk (clk),
    .rst (rst_r),
    .io  (ifa.slave)
  );

  score_ascii_keeper #(.WIN_SCORE(99), .DIG_W(14)) dut_b (
    .clk (clk),
    .rst (rst_r),
    .io  (ifb.slave)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int tens_code(input int s);
`ifdef LEAD_ZERO_BLANK_EN
    if (s / 10 == 0) return 32'h20;
`endif
    return 32'h30 + s / 10;
  endfunction

  function automatic int npl_code(input int w);
    if (w == 1) return 32'h31;
    if (w == 2) return 32'h32;
    return 32'h20;
  endfunction

  // Model: a point counts on the edge after the rise was seen
  task automatic model_step();
    bit rm, ro, rn;
    if (!rst_r) begin
      for (int k = 0; k < 2; k++) begin
        ms[k] = 0; os[k] = 0; wn[k] = 0;
      end
      {s1m, s1o, s1n, s2m, s2o, s2n} = '0;
      return;
    end
    rm = s1m && !s2m;
    ro = s1o && !s2o;
    rn = s1n && !s2n;
    for (int k = 0; k < 2; k++) begin
      if (rn) begin
        ms[k] = 0; os[k] = 0; wn[k] = 0;
      end else if (wn[k] == 0) begin
        if (rm && ms[k] < 99) ms[k]++;
        if (ro && os[k] < 99) os[k]++;
        if (rm && ms[k] == wsc[k]) wn[k] = 1;
        else if (ro && os[k] == wsc[k]) wn[k] = 2;
      end
    end
    {s2m, s2o, s2n} = {s1m, s1o, s1n};
    {s1m, s1o, s1n} = {my_r, op_r, ng_r};
  endtask

  task automatic check_dut(input string p, input int k,
                           input logic [13:0] m1,
                           input logic [13:0] m0,
                           input logic [13:0] o1,
                           input logic [13:0] o0,
                           input logic [6:0] np,
                           input logic go);
    chk({p, "_my1"}, 32'(m1), tens_code(ms[k]));
    chk({p, "_my0"}, 32'(m0), 32'h30 + ms[k] % 10);
    chk({p, "_op1"}, 32'(o1), tens_code(os[k]));
    chk({p, "_op0"}, 32'(o0), 32'h30 + os[k] % 10);
    chk({p, "_npl"}, 32'(np), npl_code(wn[k]));
    chk({p, "_go"}, 32'(go), 32'(wn[k] != 0));
  endtask

  task automatic cyc(input bit m, input bit o,
                     input bit n, input bit r);
    my_r = m; op_r = o; ng_r = n; rst_r = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_dut("a", 0, ifa.my_score_ASCII_1,
              ifa.my_score_ASCII_0, ifa.op_score_ASCII_1,
              ifa.op_score_ASCII_0, ifa.number_of_player,
              ifa.game_over);
    check_dut("b", 1, ifb.my_score_ASCII_1,
              ifb.my_score_ASCII_0, ifb.op_score_ASCII_1,
              ifb.op_score_ASCII_0, ifb.number_of_player,
              ifb.game_over);
  endtask

  task automatic pulse(input bit m, input bit o, input bit n,
                       input int hi, input int lo);
    repeat (hi) cyc(m, o, n, 1'b1);
    repeat (lo) cyc(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    repeat (3) cyc(0, 0, 0, 0);
    chk("rst_np", 32'(ifa.number_of_player), 32'h20);
    chk("rst_my0", 32'(ifa.my_score_ASCII_0), 32'h30);
    pulse(0, 0, 0, 0, 2);

    for (int i = 0; i < 3; i++) pulse(1, 0, 0, 5, 3);
    chk("cnt_my0", 32'(ifa.my_score_ASCII_0), 32'h33);

    pulse(0, 0, 1, 2, 2);
    for (int i = 0; i < 12; i++) pulse(0, 1, 0, 2, 2);
    chk("win_go", 32'(ifa.game_over), 32'h1);
    chk("win_np", 32'(ifa.number_of_player), 32'h32);
    pulse(0, 1, 0, 2, 2);
    chk("frz_op0", 32'(ifa.op_score_ASCII_0), 32'h32);

    pulse(1, 0, 1, 2, 3);
    chk("rs_go", 32'(ifa.game_over), 32'h0);
    chk("rs_my0", 32'(ifa.my_score_ASCII_0), 32'h30);

    for (int i = 0; i < 12; i++) pulse(1, 1, 0, 2, 2);
    chk("tie_np", 32'(ifa.number_of_player), 32'h31);
    chk("tie_op1", 32'(ifa.op_score_ASCII_1), 32'h31);

    pulse(0, 0, 1, 2, 2);
    for (int i = 0; i < 101; i++) pulse(1, 0, 0, 1, 1);
    chk("sat_b1", 32'(ifb.my_score_ASCII_1), 32'h39);
    chk("sat_b0", 32'(ifb.my_score_ASCII_0), 32'h39);
    chk("sat_go", 32'(ifb.game_over), 32'h1);

    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 299) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
